// File: rtl/multicore_work_scheduler.sv
// Multicore work scheduler: broadcasts a job to NUM_CORES mining cores, gives
// each core a disjoint nonce partition, times exhaustion of the partition and
// funnels golden-nonce reports round-robin onto a single valid/ready stream.
module multicore_work_scheduler #(
  parameter int LOG2_CORES = 1,
  parameter int NONCE_BITS = 32,
  parameter int JOB_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           work_valid,
  output logic                           work_ready,
  input  logic [255:0]                   work_midstate,
  input  logic [95:0]                    work_data,
  output logic [255:0]                   core_midstate,
  output logic [95:0]                    core_data,
  output logic [32*(2**LOG2_CORES)-1:0]  core_nonce_start,
  output logic                           core_load,
  input  logic [(2**LOG2_CORES)-1:0]     core_golden_valid,
  input  logic [32*(2**LOG2_CORES)-1:0]  core_golden_nonce,
  output logic                           golden_valid,
  input  logic                           golden_ready,
  output logic [31:0]                    golden_nonce,
  output logic [LOG2_CORES-1:0]          golden_core,
  output logic [JOB_W-1:0]               golden_job,
  output logic                           busy,
  output logic                           work_exhausted,
  output logic                           golden_overflow
);

  localparam int NUM_CORES = 2**LOG2_CORES;
  // Each core walks its own partition of this many nonces, one per cycle.
  localparam int CNT_W = NONCE_BITS - LOG2_CORES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [CNT_W-1:0]      counter_reg;
  logic [JOB_W-1:0]      job_id_reg;
  logic                  accept;
  logic                  counter_done;

  logic [NUM_CORES-1:0]  pending;
  logic [31:0]           slot_nonce [NUM_CORES];
  logic [JOB_W-1:0]      slot_job   [NUM_CORES];
  logic [NUM_CORES-1:0]  drop;
  logic [LOG2_CORES-1:0] rr_reg;
  logic [LOG2_CORES-1:0] grant_reg;
  logic [LOG2_CORES-1:0] grant;
  logic                  locked_reg;
  logic                  take;

  // ---------------------------------------------------------------- job FSM
  assign work_ready     = (state_reg != ST_LOAD);
  assign accept         = work_valid & work_ready;
  assign counter_done   = &counter_reg;
  assign core_load      = (state_reg == ST_LOAD);
  assign busy           = (state_reg != ST_IDLE);
  // A new job arriving in the final cycle wins over the exhaustion report.
  assign work_exhausted = (state_reg == ST_RUN) & counter_done & ~accept;

  // Next-state selection: accept preempts everything, else LOAD->RUN->IDLE.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = ST_LOAD;
    end else if (state_reg == ST_LOAD) begin
      state_next = ST_RUN;
    end else if ((state_reg == ST_RUN) && counter_done) begin
      state_next = ST_IDLE;
    end
  end

  // State, job capture, job id and partition counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      counter_reg   <= '0;
      job_id_reg    <= '0;
      core_midstate <= '0;
      core_data     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        core_midstate <= work_midstate;
        core_data     <= work_data;
        job_id_reg    <= job_id_reg + 1'b1;
        counter_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
        counter_reg <= counter_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- arbiter
  assign golden_valid = |pending;
  assign take         = golden_valid & golden_ready;
  assign golden_core  = grant;
  assign golden_nonce = slot_nonce[grant];
  assign golden_job   = slot_job[grant];

  // Round-robin search from rr upward; a stalled grant stays put.
  always_comb begin
    logic [LOG2_CORES-1:0] idx;
    grant = grant_reg;
    idx   = rr_reg;
    if (!locked_reg) begin
      grant = rr_reg;
      // Descending so the closest pending slot after rr is chosen last.
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
        idx = rr_reg + LOG2_CORES'(k);
        if (pending[idx]) begin
          grant = idx;
        end
      end
    end
  end

  // Grant hold, rr advance after a delivery, sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg          <= '0;
      grant_reg       <= '0;
      locked_reg      <= 1'b0;
      golden_overflow <= 1'b0;
    end else begin
      grant_reg  <= grant;
      locked_reg <= golden_valid & ~golden_ready;
      if (take) begin
        rr_reg <= grant + 1'b1;
      end
      if (|drop) begin
        golden_overflow <= 1'b1;
      end
    end
  end

  // ------------------------------------------------ per-core slots/partition
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
    localparam logic [LOG2_CORES-1:0] IDX = LOG2_CORES'(gi);

    logic             pending_reg;
    logic [31:0]      nonce_reg;
    logic [JOB_W-1:0] job_reg;
    logic             freed;

    // Partition base: top LOG2_CORES bits of the nonce select the core.
    assign core_nonce_start[32*gi +: 32] = 32'(gi) << CNT_W;

    assign freed          = take && (grant == IDX);
    assign drop[gi]       = core_golden_valid[gi] && pending_reg && !freed;
    assign pending[gi]    = pending_reg;
    assign slot_nonce[gi] = nonce_reg;
    assign slot_job[gi]   = job_reg;

    // Store a report if the slot is empty or being emptied this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pending_reg <= 1'b0;
        nonce_reg   <= '0;
        job_reg     <= '0;
      end else if (core_golden_valid[gi] && (!pending_reg || freed)) begin
        pending_reg <= 1'b1;
        nonce_reg   <= core_golden_nonce[32*gi +: 32];
        job_reg     <= job_id_reg;
      end else if (freed) begin
        pending_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicore_work_scheduler.sv
// Self-checking bench for multicore_work_scheduler: a cycle-level reference
// model plus a report scoreboard, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_multicore_work_scheduler;

  localparam int LOG2_CORES = 1;
  localparam int NONCE_BITS = 8;
  localparam int JOB_W      = 4;
  localparam int N          = 2**LOG2_CORES;
  localparam int PART       = 2**(NONCE_BITS - LOG2_CORES);

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  work_valid = 1'b0;
  logic                  work_ready;
  logic [255:0]          work_midstate = '0;
  logic [95:0]           work_data = '0;
  logic [255:0]          core_midstate;
  logic [95:0]           core_data;
  logic [32*N-1:0]       core_nonce_start;
  logic                  core_load;
  logic [N-1:0]          core_golden_valid = '0;
  logic [32*N-1:0]       core_golden_nonce = '0;
  logic                  golden_valid;
  logic                  golden_ready = 1'b0;
  logic [31:0]           golden_nonce;
  logic [LOG2_CORES-1:0] golden_core;
  logic [JOB_W-1:0]      golden_job;
  logic                  busy;
  logic                  work_exhausted;
  logic                  golden_overflow;

  multicore_work_scheduler #(
    .LOG2_CORES(LOG2_CORES), .NONCE_BITS(NONCE_BITS), .JOB_W(JOB_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data),
    .core_midstate(core_midstate), .core_data(core_data),
    .core_nonce_start(core_nonce_start), .core_load(core_load),
    .core_golden_valid(core_golden_valid), .core_golden_nonce(core_golden_nonce),
    .golden_valid(golden_valid), .golden_ready(golden_ready),
    .golden_nonce(golden_nonce), .golden_core(golden_core), .golden_job(golden_job),
    .busy(busy), .work_exhausted(work_exhausted), .golden_overflow(golden_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef struct { int core; logic [31:0] nonce; int job; } rep_t;
  rep_t sb[$];                       // reports waiting for delivery

  int          m_phase;              // 0 idle, 1 load, 2 run
  int          m_left;               // run cycles remaining including current
  int          m_job;
  int          m_rr;
  bit          m_locked;
  int          m_grant;
  bit          m_ovf;
  logic [255:0] m_mid;
  logic [95:0]  m_data;
  logic [32*N-1:0] m_starts;

  int cyc = 0;
  int acc_cyc = -1;
  int exh_cyc = -1;
  int last_job = -1;
  logic [31:0] last_nonce = '0;
  int deliv[$];

  function automatic int find_core(input int c);
    foreach (sb[i]) if (sb[i].core == c) return i;
    return -1;
  endfunction

  initial begin
    for (int c = 0; c < N; c++) m_starts[32*c +: 32] = 32'(c * PART);
  end

  // Monitor: compare every cycle against the model, then advance the model.
  always @(negedge clk) begin
    bit e_ready, e_exh, e_gv, acc, tk;
    int e_grant, idx, c2;
    cyc++;
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_job = 0; m_rr = 0; m_locked = 0; m_grant = 0;
      m_ovf = 0; m_mid = '0; m_data = '0;
      sb.delete();
    end
    e_ready = (m_phase != 1);
    acc     = reset_n && work_valid && e_ready;
    e_exh   = (m_phase == 2) && (m_left == 1) && !acc;
    e_gv    = (sb.size() > 0);
    e_grant = m_grant;
    if (!m_locked) begin
      e_grant = m_rr;
      for (int k = N - 1; k >= 0; k--) begin
        c2 = (m_rr + k) % N;
        if (find_core(c2) >= 0) e_grant = c2;
      end
    end

    chk("work_ready", work_ready, e_ready);
    chk("busy", busy, m_phase != 0);
    chk("core_load", core_load, m_phase == 1);
    chk("work_exhausted", work_exhausted, e_exh);
    chk("golden_valid", golden_valid, e_gv);
    chk("golden_overflow", golden_overflow, m_ovf);
    chk("core_midstate", core_midstate, m_mid);
    chk("core_data", core_data, m_data);
    chk("core_nonce_start", core_nonce_start, m_starts);
    if (e_gv) begin
      idx = find_core(e_grant);
      chk("golden_core", golden_core, e_grant);
      if (idx >= 0) begin
        chk("golden_nonce", golden_nonce, sb[idx].nonce);
        chk("golden_job", golden_job, sb[idx].job);
      end
    end
    if (work_exhausted) exh_cyc = cyc;

    if (reset_n) begin
      if (acc) acc_cyc = cyc;
      tk = e_gv && golden_ready;
      if (tk) begin
        idx = find_core(e_grant);
        if (idx >= 0) begin
          last_nonce = sb[idx].nonce;
          last_job   = sb[idx].job;
          $display("REPORT core=%0d nonce=%08h job=%0d (dut core=%0d nonce=%08h job=%0d)",
                   e_grant, sb[idx].nonce, sb[idx].job, golden_core, golden_nonce, golden_job);
          sb.delete(idx);
        end
        deliv.push_back(e_grant);
        m_rr = (e_grant + 1) % N;
      end
      m_locked = e_gv && !golden_ready;
      m_grant  = e_grant;
      for (int c = 0; c < N; c++) begin
        if (core_golden_valid[c]) begin
          if (find_core(c) >= 0) m_ovf = 1'b1;
          else sb.push_back('{c, core_golden_nonce[32*c +: 32], m_job});
        end
      end
      if (acc) begin
        m_job   = (m_job + 1) % (2**JOB_W);
        m_mid   = work_midstate;
        m_data  = work_data;
        m_phase = 1;
        $display("JOB accept id=%0d cycle=%0d", m_job, cyc);
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_left  = PART;
      end else if (m_phase == 2) begin
        if (m_left == 1) m_phase = 0;
        else m_left--;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_job(input logic [255:0] mid, input logic [95:0] dat);
    work_valid    = 1'b1;
    work_midstate = mid;
    work_data     = dat;
    step();
    work_valid = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [31:0] nonce);
    core_golden_valid[c]         = 1'b1;
    core_golden_nonce[32*c +: 32] = nonce;
  endtask

  initial begin
    logic [255:0] mid1;
    logic [95:0]  dat1;
    mid1 = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
    dat1 = 96'h2194261a9395e64dbed17115;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_nonce_start", core_nonce_start, 64'h00000080_00000000);
    chk("rst_work_ready", work_ready, 1'b1);
    reset_n = 1'b1;
    step();

    // Two simultaneous reports while the consumer stalls, then drain.
    deliv.delete();
    pulse(0, 32'h0e33337a);
    pulse(1, 32'h0e3333fa);
    golden_ready = 1'b0;
    step();
    core_golden_valid = '0;
    repeat (4) step();
    chk("stall_core", golden_core, 0);
    golden_ready = 1'b1;
    repeat (3) step();
    golden_ready = 1'b0;
    chk("rr_count", deliv.size(), 2);
    if (deliv.size() == 2) begin
      chk("rr_first", deliv[0], 0);
      chk("rr_second", deliv[1], 1);
    end

    // Full job to exhaustion.
    exh_cyc = -1;
    offer_job(mid1, dat1);
    chk("load_pulse", core_load, 1'b1);
    chk("load_midstate", core_midstate, mid1);
    chk("load_data", core_data, dat1);
    repeat (140) step();
    chk("exh_latency", exh_cyc - acc_cyc, PART + 1);
    chk("idle_after", busy, 1'b0);

    // Preempting job accepted 50 cycles into RUN.
    offer_job(mid1 ^ 256'h1, dat1 ^ 96'h1);
    step();
    repeat (50) step();
    exh_cyc = -1;
    offer_job(mid1 ^ 256'h2, dat1 ^ 96'h2);
    step();
    pulse(1, 32'h1234_5678);
    step();
    core_golden_valid = '0;
    golden_ready = 1'b1;
    repeat (2) step();
    golden_ready = 1'b0;
    chk("job_tag", last_job, 3);
    repeat (130) step();
    chk("preempt_exh_latency", exh_cyc - acc_cyc, PART + 1);

    // Double report from core 1 while blocked: second one dropped.
    pulse(1, 32'haaaa_0001);
    step();
    core_golden_valid = '0;
    step();
    pulse(1, 32'haaaa_0002);
    step();
    core_golden_valid = '0;
    chk("ovf_set", golden_overflow, 1'b1);
    golden_ready = 1'b1;
    repeat (3) step();
    golden_ready = 1'b0;
    chk("ovf_first_kept", last_nonce, 32'haaaa_0001);
    chk("ovf_sticky", golden_overflow, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      work_valid = ($urandom_range(0, 99) == 0);
      for (int w = 0; w < 8; w++) work_midstate[32*w +: 32] = $urandom;
      for (int w = 0; w < 3; w++) work_data[32*w +: 32] = $urandom;
      for (int c = 0; c < N; c++) begin
        core_golden_valid[c]         = ($urandom_range(0, 7) == 0);
        core_golden_nonce[32*c +: 32] = $urandom;
      end
      golden_ready = $urandom_range(0, 1);
      step();
    end
    work_valid = 1'b0;
    core_golden_valid = '0;
    golden_ready = 1'b0;
    step();

    // Reset mid-RUN with a pending report.
    offer_job(mid1, dat1);
    repeat (30) step();
    pulse(0, 32'hdead_beef);
    step();
    core_golden_valid = '0;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_valid", golden_valid, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("rst_slot_gone", golden_valid, 1'b0);
    chk("rst_ovf_clear", golden_overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
